seq_stage_controller: RTL and testbench
=======================================

# seq_stage_controller

Stage sequencer for the Y86-64 sequential processor. It steps the fetch, decode, execute, memory, write-back and PC-update logic one stage per clock by driving one-hot stage enables. It latches the fetched `icode`, skips the memory stage for instructions that do not access memory, and waits on a data-memory handshake. It also tracks processor status (AOK/HLT/ADR/INS) and counts cycles and retired instructions. It sits above `fetch`, `decode` and the later stages and replaces manual clock/PC stepping in benches.

## Interface
- `CNT_W`, default 32: width of the cycle and instruction counters.
- `MEM_TIMEOUT`, default 15: maximum memory-stage wait cycles before an address fault.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begins execution; honoured only in IDLE.
- `icode`  in  4: instruction code from `fetch`, sampled in FETCH.
- `instr_valid`  in  1: fetch/decode reports a legal `icode`/`ifun`.
- `imem_error`  in  1: instruction-memory address error, sampled in FETCH.
- `dmem_ready`  in  1: data-memory access complete, sampled in MEMORY.
- `dmem_error`  in  1: data-memory address error, sampled in MEMORY.
- `fetch_en`, `decode_en`, `execute_en`, `memory_en`, `writeback_en`, `pc_en`  out  1 each: stage enables, at most one high per cycle.
- `icode_q`  out  4: latched `icode` of the instruction in flight.
- `stat`  out  3: status code, 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `halted`  out  1: high in HALT.
- `cycle_count`  out  CNT_W: active cycles.
- `instr_count`  out  CNT_W: retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Stage enables are a Moore decode of state; each enable is high exactly while in its state. All enables are 0 in IDLE and HALT.
- IDLE → FETCH when `start`=1.
- FETCH, priority order:
  - `imem_error` → HALT, stat=ADR.
  - else `!instr_valid` → HALT, stat=INS.
  - else `icode`=0 (halt) → HALT, stat=HLT, `icode_q`=0, `instr_count`+1.
  - else latch `icode_q` ← `icode` → DECODE.
- DECODE → EXECUTE.
- EXECUTE → MEMORY if `icode_q` ∈ {4,5,8,9,A,B}; otherwise → WRITEBACK.
- MEMORY, each cycle, priority order:
  - `dmem_error` → HALT, stat=ADR.
  - else `dmem_ready` → WRITEBACK.
  - else wait counter +1. When the counter reaches MEM_TIMEOUT with `dmem_ready` still 0 → HALT, stat=ADR.
  - The wait counter clears on entry to MEMORY.
- WRITEBACK → PCUPD.
- PCUPD → FETCH; `instr_count`+1 in this cycle.
- HALT is sticky: `start` is ignored and only `reset` exits it.
- `start` is ignored in every state except IDLE.
- `cycle_count` increments every cycle the state is not IDLE or HALT.
- Both counters saturate at 2^CNT_W−1; there is no wrap-around.
- `stat` stays AOK until a fault or halt, then holds its value.

## Timing
- Reset values: state=IDLE, all enables 0, `icode_q`=0, `stat`=1 (AOK), `halted`=0, both counters 0, wait counter 0.
- `reset` has priority over every other input. Asserting it mid-instruction returns to IDLE on the next edge and discards all in-flight state.
- `start` sampled at edge N puts `fetch_en` high in cycle N+1.
- Non-memory instruction: 5 cycles (F, D, E, W, P).
- Memory instruction: 6 cycles plus the number of cycles `dmem_ready` is low.
- `pc_en` is high in the last cycle of each instruction. FETCH of the next instruction follows in the very next cycle with no bubble.
- Outputs are registered or state-decoded; there is no combinational path from inputs to outputs.
- If `dmem_error` and `dmem_ready` are both high in the same cycle, the error wins.
- If `imem_error` and `!instr_valid` are both true, ADR wins.

## Test plan
- Reset, then pulse `start` with `icode`=3 (irmovq), then `icode`=0:
  - Enables go F, D, E, W, P in cycles 1–5; `fetch_en` high in cycle 6.
  - Then HALT with stat=2, `halted`=1, `instr_count`=2, `cycle_count`=6.
- `icode`=5 (mrmovq) with `dmem_ready` low for 3 cycles:
  - `memory_en` high for 4 consecutive cycles, then W, P.
  - `cycle_count`=9 at PCUPD; `instr_count`=1.
- `imem_error`=1 in FETCH: HALT, stat=3, `instr_count`=0.
- Separate run with `instr_valid`=0: stat=4.
- Pulse `start` in HALT: no change.
- `icode`=A (pushq) with `dmem_ready` held at 0: after MEM_TIMEOUT=15 wait cycles → HALT, stat=3.
- Separate run with `dmem_error`=1 and `dmem_ready`=1 together: stat=3.
- Assert `reset` during EXECUTE of the second instruction:
  - Next cycle IDLE, all enables 0, counters 0, stat=1.
  - A new `start` re-runs from FETCH.

Source files
------------

// File: rtl/seq_stage_controller.sv
// -----------------------------------------------------------------------------
// seq_stage_controller
//
// Stage sequencer for a sequential Y86-64 core. It walks the datapath through
// FETCH, DECODE, EXECUTE, [MEMORY], WRITEBACK and PCUPD, one stage per clock,
// by raising exactly one stage enable per cycle. It also tracks processor
// status and counts active cycles and retired instructions.
//
// Parameters
//   CNT_W        width of cycle_count / instr_count (both saturate)
//   MEM_TIMEOUT  memory-stage wait cycles tolerated before an address fault
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (priority over all inputs)
//   start        begin execution; only honoured in IDLE
//   icode        instruction code from fetch, sampled in FETCH
//   instr_valid  fetch/decode reports a legal icode/ifun
//   imem_error   instruction memory address error, sampled in FETCH
//   dmem_ready   data memory access complete, sampled in MEMORY
//   dmem_error   data memory address error, sampled in MEMORY
//   *_en         one-hot stage enables (all low in IDLE and HALT)
//   icode_q      latched icode of the instruction in flight
//   stat         1=AOK 2=HLT 3=ADR 4=INS
//   halted       high while in HALT
//   cycle_count  cycles spent outside IDLE/HALT
//   instr_count  retired instructions
// -----------------------------------------------------------------------------
module seq_stage_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic [3:0]       icode_q,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // Value of the wait counter during the last tolerated not-ready cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        icode_lat_q, icode_lat_d;
    logic [2:0]        stat_q, stat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_q, instr_q;
    logic              retire;
    logic              mem_access;

    // mrmovq, rmmovq, call, ret, pushq, popq touch data memory.
    assign mem_access = (icode_lat_q == 4'h4) || (icode_lat_q == 4'h5) ||
                        (icode_lat_q == 4'h8) || (icode_lat_q == 4'h9) ||
                        (icode_lat_q == 4'hA) || (icode_lat_q == 4'hB);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        icode_lat_d = icode_lat_q;
        stat_d      = stat_q;
        wait_d      = wait_q;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    // The halt instruction itself counts as retired.
                    state_d     = S_HALT;
                    stat_d      = STAT_HLT;
                    icode_lat_d = 4'h0;
                    retire      = 1'b1;
                end else begin
                    state_d     = S_DECODE;
                    icode_lat_d = icode;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (mem_access) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    // This not-ready cycle would bring the count to MEM_TIMEOUT.
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore stage-enable decode
    // ------------------------------------------------------------------
    always_comb begin
        fetch_en     = (state_q == S_FETCH);
        decode_en    = (state_q == S_DECODE);
        execute_en   = (state_q == S_EXECUTE);
        memory_en    = (state_q == S_MEMORY);
        writeback_en = (state_q == S_WRITEBACK);
        pc_en        = (state_q == S_PCUPD);
        halted       = (state_q == S_HALT);
    end

    // ------------------------------------------------------------------
    // State, status and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            icode_lat_q <= 4'h0;
            stat_q      <= STAT_AOK;
            wait_q      <= '0;
            cycle_q     <= '0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            icode_lat_q <= icode_lat_d;
            stat_q      <= stat_d;
            wait_q      <= wait_d;
            if ((state_q != S_IDLE) && (state_q != S_HALT) && (cycle_q != '1)) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (retire && (instr_q != '1)) begin
                instr_q <= instr_q + 1'b1;
            end
        end
    end

    assign icode_q     = icode_lat_q;
    assign stat        = stat_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for seq_stage_controller. Inputs change 1 ns after the
// rising edge and outputs are sampled there too, so every value seen reflects
// the state entered on the preceding edge.
// -----------------------------------------------------------------------------
module tb_seq_stage_controller;

    localparam logic [5:0] EN_NONE = 6'b000000;
    localparam logic [5:0] EN_F    = 6'b100000;
    localparam logic [5:0] EN_D    = 6'b010000;
    localparam logic [5:0] EN_E    = 6'b001000;
    localparam logic [5:0] EN_M    = 6'b000100;
    localparam logic [5:0] EN_W    = 6'b000010;
    localparam logic [5:0] EN_P    = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        dmem_error = 1'b0;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
    logic [3:0]  icode_q;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] cycle_count, instr_count;
    logic [5:0]  en;

    int checks = 0;
    int failures = 0;
    int mem_cycles;

    assign en = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};

    always #5 clk = ~clk;

    seq_stage_controller #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .icode        (icode),
        .instr_valid  (instr_valid),
        .imem_error   (imem_error),
        .dmem_ready   (dmem_ready),
        .dmem_error   (dmem_error),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .memory_en    (memory_en),
        .writeback_en (writeback_en),
        .pc_en        (pc_en),
        .icode_q      (icode_q),
        .stat         (stat),
        .halted       (halted),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        icode       = 4'h0;
        instr_valid = 1'b1;
        imem_error  = 1'b0;
        dmem_ready  = 1'b0;
        dmem_error  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Issue start from IDLE; returns in the FETCH cycle.
    task automatic launch(input logic [3:0] code);
        icode = code;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_en", en, EN_NONE);
        check("rst_stat", stat, 3'd1);
        check("rst_halted", halted, 1'b0);
        check("rst_icode_q", icode_q, 4'h0);
        check("rst_cycles", cycle_count, 0);
        check("rst_instrs", instr_count, 0);

        // ---------------- irmovq then halt ----------------
        launch(4'h3);
        check("irm_c1_F", en, EN_F);
        step(); check("irm_c2_D", en, EN_D);
        check("irm_icode_q", icode_q, 4'h3);
        step(); check("irm_c3_E", en, EN_E);
        step(); check("irm_c4_W", en, EN_W);
        step(); check("irm_c5_P", en, EN_P);
        icode = 4'h0;
        step(); check("irm_c6_F", en, EN_F);
        step();
        check("hlt_en", en, EN_NONE);
        check("hlt_halted", halted, 1'b1);
        check("hlt_stat", stat, 3'd2);
        check("hlt_icode_q", icode_q, 4'h0);
        check("hlt_instrs", instr_count, 2);
        check("hlt_cycles", cycle_count, 6);

        // start in HALT is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("hlt_sticky_halted", halted, 1'b1);
        check("hlt_sticky_en", en, EN_NONE);
        check("hlt_sticky_cycles", cycle_count, 6);

        // ---------------- mrmovq, dmem_ready low for 3 cycles ----------------
        do_reset();
        launch(4'h5);
        step(); check("mrm_D", en, EN_D);
        step(); check("mrm_E", en, EN_E);
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mrm_M%0d", i), en, EN_M);
            if (i == 3) dmem_ready = 1'b1;
            step();
        end
        check("mrm_W", en, EN_W);
        dmem_ready = 1'b0;
        step(); check("mrm_P", en, EN_P);
        icode = 4'h0;
        step();
        // Counters after the PCUPD cycle has completed.
        check("mrm_next_F", en, EN_F);
        check("mrm_cycles", cycle_count, 9);
        check("mrm_instrs", instr_count, 1);

        // ---------------- imem_error together with invalid instr ----------------
        do_reset();
        imem_error  = 1'b1;
        instr_valid = 1'b0;
        launch(4'h3);
        step();
        check("imem_halted", halted, 1'b1);
        check("imem_stat_adr", stat, 3'd3);
        check("imem_instrs", instr_count, 0);

        // ---------------- invalid instruction ----------------
        do_reset();
        instr_valid = 1'b0;
        launch(4'hF);
        step();
        check("ins_halted", halted, 1'b1);
        check("ins_stat", stat, 3'd4);
        instr_valid = 1'b1;

        // ---------------- pushq with dmem_ready stuck low ----------------
        do_reset();
        launch(4'hA);
        step(); step();
        check("push_E", en, EN_E);
        step();
        mem_cycles = 0;
        for (int i = 0; i < 40 && memory_en; i++) begin
            mem_cycles++;
            step();
        end
        check("push_mem_cycles", mem_cycles, 15);
        check("push_halted", halted, 1'b1);
        check("push_stat", stat, 3'd3);

        // ---------------- dmem_error and dmem_ready together ----------------
        do_reset();
        launch(4'h4);
        step(); step(); step();
        check("rmm_M", en, EN_M);
        dmem_error = 1'b1;
        dmem_ready = 1'b1;
        step();
        check("dmerr_halted", halted, 1'b1);
        check("dmerr_stat", stat, 3'd3);
        dmem_error = 1'b0;
        dmem_ready = 1'b0;

        // ---------------- reset during EXECUTE of second instruction ----------------
        do_reset();
        launch(4'h6);
        step(); step(); step(); step();
        check("op1_P", en, EN_P);
        step(); step(); step();
        check("op2_E", en, EN_E);
        check("op2_instrs", instr_count, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_en", en, EN_NONE);
        check("mid_rst_cycles", cycle_count, 0);
        check("mid_rst_instrs", instr_count, 0);
        check("mid_rst_stat", stat, 3'd1);
        check("mid_rst_icode_q", icode_q, 4'h0);
        launch(4'h2);
        check("rerun_F", en, EN_F);
        step();
        check("rerun_D", en, EN_D);
        check("rerun_cycles", cycle_count, 1);
        check("rerun_icode_q", icode_q, 4'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
